muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers, sitting beside the combinational ALU in the execute stage of the pipeline. It accepts one operation per start pulse, computes signed or unsigned WIDTH×WIDTH products and WIDTH/WIDTH quotients/remainders over multiple cycles, and exposes `busy` so the hazard unit can stall dependent HI/LO reads. It also handles single-cycle direct writes to HI and LO.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; must be ≥ 4.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request, sampled only while idle.
- `op` in 3: 3'b001 multiply, 3'b010 divide, 3'b011 write HI, 3'b100 write LO; other codes are no-ops.
- `Sign` in 1: 1 = two's-complement operands, 0 = unsigned; same meaning as the ALU's `Sign`.
- `in1` in WIDTH: multiplicand / dividend / HI-LO write data.
- `in2` in WIDTH: multiplier / divisor.
- `busy` out 1: registered; high while an iterative operation is in flight.
- `done` out 1: registered one-cycle pulse; HI/LO hold the new result in the same cycle.
- `div_by_zero` out 1: registered; valid only when `done` is high.
- `hi` out WIDTH: HI register (product upper half / remainder).
- `lo` out WIDTH: LO register (product lower half / quotient).

## Operation
- States: IDLE, CALC, FIX. Reset forces IDLE with `hi`=`lo`=0 and `busy`=`done`=`div_by_zero`=0. Reset asserted mid-operation aborts the operation: no `done`, and HI/LO are zeroed.
- IDLE, `start`, `op`=001/010: latch operand magnitudes and the result signs, clear the iteration counter, go to CALC.
- IDLE, `start`, `op`=011/100: write `in1` to HI/LO at that edge. No `busy`, no `done`. Stay in IDLE.
- CALC: one iteration per cycle on magnitudes, WIDTH iterations total.
  - Multiply is shift-add into a 2·WIDTH accumulator.
  - Divide is restoring shift-subtract.
  - After iteration WIDTH, go to FIX.
- FIX applies the sign correction, writes HI/LO, pulses `done`, and returns to IDLE.
- Signed result rules:
  - Product: negated if the operand signs differ.
  - Quotient: negated if the operand signs differ.
  - Remainder: takes the dividend's sign.
- Divide by zero: `lo` = all ones, `hi` = `in1` unmodified (both signed and unsigned), `div_by_zero`=1.
- Signed MIN / −1: `lo` = MIN, `hi` = 0. No flag.
- `start` while not in IDLE is ignored, including HI/LO writes. The requester must hold the request until it sees `busy`=0.
- Unused op codes with `start` have no effect.

## Timing
- Edge E0 accepts `start`. `busy`=1 after E0.
- Edges E1..E(WIDTH) are iterations. Edge E(WIDTH+1) is FIX.
- After E(WIDTH+1): `busy`=0, `done`=1 for exactly one cycle, `hi`/`lo` updated.
- Latency from start to done is WIDTH+1 cycles; `busy` stays high for WIDTH+1 cycles.
- A new `start` is accepted in the `done` cycle, giving back-to-back issue every WIDTH+2 cycles.
- A HI/LO write takes effect at the accepting edge, so it is visible in the next cycle.
- `hi`/`lo` are unchanged throughout CALC. Intermediate values are held in internal registers only.

## Configuration
- `MULDIV_DIVIDER_EN` defined: the divide datapath is built and `op`=010 behaves as above.
- Not defined: the divider logic is omitted entirely.
  - `op`=010 is treated as an unused code: no `busy`, no `done`, HI/LO unchanged.
  - `div_by_zero` is tied to 0.

## Test plan
- Unsigned multiply: `Sign`=0, 0xFFFFFFFF×0xFFFFFFFF (WIDTH=32) → `hi`=0xFFFFFFFE, `lo`=0x00000001. `done` arrives exactly 33 cycles after the start edge, and `busy` is high for 33 cycles.
- Signed multiply: `Sign`=1, −3×7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
  - Unsigned: 0x80000000×2 → `hi`=1, `lo`=0.
- Divide: signed −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - Unsigned 7/2 → `lo`=3, `hi`=1.
  - Signed 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Divide by zero: 0x12345678/0 → `lo`=0xFFFFFFFF, `hi`=0x12345678, `div_by_zero`=1 with `done`. The next normal divide shows `div_by_zero`=0.
- Collisions and reset:
  - A `start` multiply and a write-HI issued during `busy` are both ignored.
  - Write-LO 0xA5A5A5A5 in IDLE → `lo`=0xA5A5A5A5 next cycle.
  - `reset` at iteration 10 → `busy`=0, `hi`=`lo`=0 next cycle, and no `done` ever follows.
- Build without `MULDIV_DIVIDER_EN`: a divide start leaves `busy`=0 and `done`=0 and HI/LO unchanged, while multiply results still match the scenarios above.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Define MULDIV_DIVIDER_EN to build the divide datapath; otherwise op 3'b010 is a no-op.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             Sign,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned      CntW     = $clog2(WIDTH);
  localparam logic [CntW-1:0]  LastIter = CntW'(WIDTH - 1);
  localparam logic [2:0]       OpMul    = 3'b001;
  localparam logic [2:0]       OpWrHi   = 3'b011;
  localparam logic [2:0]       OpWrLo   = 3'b100;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e               state_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     mcand_q;   // multiplicand magnitude, or divisor magnitude
  logic [CntW-1:0]      cnt_q;
  logic                 neg_lo_q;  // negate product / quotient

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH-1:0]     mul_addend;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [2*WIDTH-1:0]   prod;

  assign a_neg = Sign & in1[WIDTH-1];
  assign b_neg = Sign & in2[WIDTH-1];
  assign a_mag = a_neg ? -in1 : in1;
  assign b_mag = b_neg ? -in2 : in2;

  // Shift-add: low half of acc holds the remaining multiplier bits.
  always_comb begin
    mul_addend = acc_q[0] ? mcand_q : '0;
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    mul_next   = {mul_sum, acc_q[WIDTH-1:1]};
    prod       = neg_lo_q ? -acc_q : acc_q;
  end

`ifdef MULDIV_DIVIDER_EN
  localparam logic [2:0] OpDiv = 3'b010;

  logic                 is_div_q;
  logic                 zero_div_q;
  logic                 neg_hi_q;    // remainder follows the dividend's sign
  logic [WIDTH-1:0]     dividend_q;  // raw in1, returned in HI on divide by zero

  logic [WIDTH:0]       div_trial;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [WIDTH-1:0]     quo, rem;

  // Restoring divide: acc = {partial remainder, dividend bits shifting into quotient}.
  always_comb begin
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, mcand_q};
    if (!div_diff[WIDTH]) begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
    quo = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      mcand_q     <= '0;
      cnt_q       <= '0;
      neg_lo_q    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
`ifdef MULDIV_DIVIDER_EN
      is_div_q    <= 1'b0;
      zero_div_q  <= 1'b0;
      neg_hi_q    <= 1'b0;
      dividend_q  <= '0;
      div_by_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            case (op)
              OpMul: begin
                acc_q    <= {{WIDTH{1'b0}}, b_mag};
                mcand_q  <= a_mag;
                neg_lo_q <= a_neg ^ b_neg;
                cnt_q    <= '0;
                busy     <= 1'b1;
                state_q  <= StCalc;
`ifdef MULDIV_DIVIDER_EN
                is_div_q <= 1'b0;
`endif
              end
`ifdef MULDIV_DIVIDER_EN
              OpDiv: begin
                acc_q      <= {{WIDTH{1'b0}}, a_mag};
                mcand_q    <= b_mag;
                neg_lo_q   <= a_neg ^ b_neg;
                neg_hi_q   <= a_neg;
                is_div_q   <= 1'b1;
                zero_div_q <= (in2 == '0);
                dividend_q <= in1;
                cnt_q      <= '0;
                busy       <= 1'b1;
                state_q    <= StCalc;
              end
`endif
              OpWrHi:  hi <= in1;
              OpWrLo:  lo <= in1;
              default: ;
            endcase
          end
        end
        StCalc: begin
`ifdef MULDIV_DIVIDER_EN
          acc_q <= is_div_q ? div_next : mul_next;
`else
          acc_q <= mul_next;
`endif
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastIter) state_q <= StFix;
        end
        StFix: begin
`ifdef MULDIV_DIVIDER_EN
          if (is_div_q) begin
            if (zero_div_q) begin
              lo          <= '1;
              hi          <= dividend_q;
              div_by_zero <= 1'b1;
            end else begin
              lo          <= quo;
              hi          <= rem;
              div_by_zero <= 1'b0;
            end
          end else begin
            hi          <= prod[2*WIDTH-1:WIDTH];
            lo          <= prod[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
`else
          hi <= prod[2*WIDTH-1:WIDTH];
          lo <= prod[WIDTH-1:0];
`endif
          busy    <= 1'b0;
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised self-checking bench for muldiv_unit against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk, reset, start, sign;
  logic [2:0]   op;
  logic [W-1:0] in1, in2;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  logic [W-1:0] exp_hi, exp_lo;
  int           n_checks, n_errors;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .Sign        (sign),
    .in1         (in1),
    .in2         (in2),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit integer arithmetic, SV's truncating division and dividend-signed %.
  function automatic void model(input logic [2:0] opc, input logic s, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] rh,
                                output logic [W-1:0] rl, output logic rdz);
    longint      sa, sb;
    logic [63:0] p, q, r;
    sa  = s ? longint'($signed(a)) : longint'({32'b0, a});
    sb  = s ? longint'($signed(b)) : longint'({32'b0, b});
    rdz = 1'b0;
    if (opc == 3'b001) begin
      p  = 64'(sa * sb);
      rh = p[63:32];
      rl = p[31:0];
    end else if (b == 0) begin
      rl  = '1;
      rh  = a;
      rdz = 1'b1;
    end else begin
      q  = 64'(sa / sb);
      r  = 64'(sa % sb);
      rl = q[31:0];
      rh = r[31:0];
    end
  endfunction

  // Called at a negedge; returns at the negedge where done is seen (or the bound expires).
  task automatic issue_calc(input logic [2:0] opc, input logic s, input logic [W-1:0] a,
                            input logic [W-1:0] b, input bit collide);
    logic [W-1:0] eh, el;
    logic         edz;
    int           cycles, busy_cnt;
    bit           held;
    model(opc, s, a, b, eh, el, edz);
    start = 1'b1; op = opc; sign = s; in1 = a; in2 = b;
    @(negedge clk);
    start = 1'b0;
    cycles = 0; busy_cnt = 0; held = 1'b1;
    while (!done && cycles < 4 * W) begin
      if (busy) busy_cnt++;
      if (hi !== exp_hi || lo !== exp_lo) held = 1'b0;
      if (collide && cycles == 5) begin
        start = 1'b1; op = 3'b011; in1 = 32'hDEAD_BEEF;
      end else if (collide && cycles == 6) begin
        op = 3'b001; in1 = 32'h0000_0003; in2 = 32'h0000_0005;
      end else if (collide && cycles == 7) begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    check("latency", 64'(cycles), 64'(W + 1));
    check("busy_len", 64'(busy_cnt), 64'(W + 1));
    check("busy_at_done", 64'(busy), 64'd0);
    check("hilo_hold", 64'(held), 64'd1);
    check("hi", 64'(hi), 64'(eh));
    check("lo", 64'(lo), 64'(el));
    check("div_by_zero", 64'(div_by_zero), 64'(edz));
    exp_hi = eh;
    exp_lo = el;
  endtask

  task automatic issue_noop(input logic [2:0] opc);
    bit quiet;
    quiet = 1'b1;
    start = 1'b1; op = opc; sign = 1'($urandom); in1 = $urandom; in2 = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      if (busy || done) quiet = 1'b0;
      @(negedge clk);
    end
    check("noop_quiet", 64'(quiet), 64'd1);
    check("noop_hi", 64'(hi), 64'(exp_hi));
    check("noop_lo", 64'(lo), 64'(exp_lo));
  endtask

  task automatic issue_write(input bit to_hi, input logic [W-1:0] data);
    start = 1'b1; op = to_hi ? 3'b011 : 3'b100; in1 = data;
    @(negedge clk);
    start = 1'b0;
    if (to_hi) exp_hi = data;
    else exp_lo = data;
    check(to_hi ? "wr_hi" : "wr_lo", {hi, lo}, {exp_hi, exp_lo});
    check("wr_no_busy", 64'(busy || done), 64'd0);
  endtask

  task automatic do_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULDIV_DIVIDER_EN
    issue_calc(3'b010, s, a, b, 1'b0);
`else
    issue_noop(3'b010);
`endif
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      default: return $urandom;
    endcase
  endfunction

  task automatic reset_mid_op();
    bit saw_done;
    start = 1'b1; op = 3'b001; sign = 1'b0; in1 = '1; in2 = '1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    saw_done = 1'b0;
    repeat (2 * W) begin
      if (done || busy) saw_done = 1'b1;
      @(negedge clk);
    end
    check("rst_no_done", 64'(saw_done), 64'd0);
    exp_hi = '0;
    exp_lo = '0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    clk = 1'b0; reset = 1'b1; start = 1'b0; op = '0; sign = 1'b0; in1 = '0; in2 = '0;
    exp_hi = '0; exp_lo = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {59'd0, busy, done, div_by_zero, |hi, |lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    issue_calc(3'b001, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue_calc(3'b001, 1'b1, -32'sd3, 32'd7, 1'b0);
    issue_calc(3'b001, 1'b0, 32'h8000_0000, 32'd2, 1'b0);
    do_div(1'b1, -32'sd7, 32'd2);
    do_div(1'b0, 32'd7, 32'd2);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_div(1'b0, 32'h1234_5678, 32'd0);
    do_div(1'b1, 32'd100, 32'd9);
    issue_calc(3'b001, 1'b1, 32'h1234_5678, 32'hFFFF_FFF0, 1'b1);
    issue_write(1'b0, 32'hA5A5_A5A5);
    issue_write(1'b1, 32'h5A5A_0F0F);
    for (int i = 0; i < 4; i++) issue_noop(3'($urandom_range(5, 7)));
    issue_noop(3'b000);
    reset_mid_op();

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: issue_calc(3'b001, 1'($urandom), pick(), pick(), 1'b0);
        5, 6, 7, 8:    do_div(1'($urandom), pick(), pick());
        default:       issue_write(1'($urandom), $urandom);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
